// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing constants for the KEY0 debouncer.
// The state encoding is reused by anything that needs to decode the debouncer state.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        UP,
        WAIT_DOWN,
        DOWN,
        WAIT_UP
    } state_t;

    // 20 ms settle time, 500 ms to first repeat, 100 ms repeat interval at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5_000_000;

    // Accepted key level implied by a state: 1 = pressed.
    function automatic logic is_down(state_t s);
        return (s == DOWN) || (s == WAIT_UP);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VALUE sets the level both flops take under reset.
module sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: flops use non-blocking assignments so every register samples the pre-edge value;
    // blocking here would collapse the two stages into one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Debounces the active-low KEY0 into a clean level A plus one-cycle PRESS/RELEASE strobes.
// Defining KEY_DEBOUNCER_AUTOREPEAT_EN adds auto-repeat PRESS strobes while the key is held.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic CLK50M,
    input  logic RST,
    input  logic KEY0,
    output logic A,
    output logic PRESS,
    output logic RELEASE
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_raw_s;
    logic             key_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             a_q, press_q, release_q;
    logic             fire;

    sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk_i (CLK50M),
        .rst_i (RST),
        .d_i   (KEY0),
        .q_o   (key_raw_s)
    );

    assign key_s   = ~key_raw_s;
    assign level_q = is_down(state_q);

    // The counter holds how many consecutive cycles key_s has disagreed with the
    // accepted level, so reaching CNT_LAST means this cycle is the Nth disagreement.
    // NOTE: every combinational output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UP:        if (key_s)          state_d = (cnt_q == CNT_LAST) ? DOWN : WAIT_DOWN;
            WAIT_DOWN: if (!key_s)         state_d = UP;
                       else if (cnt_q == CNT_LAST) state_d = DOWN;
            DOWN:      if (!key_s)         state_d = (cnt_q == CNT_LAST) ? UP : WAIT_UP;
            WAIT_UP:   if (key_s)          state_d = DOWN;
                       else if (cnt_q == CNT_LAST) state_d = UP;
            default:                       state_d = UP;
        endcase

        level_d = is_down(state_d);
        if (key_s == level_d) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            state_q   <= UP;
            cnt_q     <= '0;
            a_q       <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Edge detection on the accepted level; only one direction can be true.
            a_q       <= level_q;
            press_q   <= (level_q & ~a_q) | fire;
            release_q <= ~level_q & a_q;
        end
    end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             repeating_q, repeating_d;

    // Counts from the cycle PRESS is visible; WAIT_UP holds the count, UP/WAIT_DOWN clear it.
    always_comb begin
        rpt_d       = rpt_q;
        repeating_d = repeating_q;
        fire        = 1'b0;
        if (!level_q) begin
            rpt_d       = '0;
            repeating_d = 1'b0;
        end else if (state_q == DOWN && a_q) begin
            if (rpt_q == (repeating_q ? RPT_PERIOD_V : RPT_DELAY_V)) begin
                fire        = 1'b1;
                rpt_d       = RPT_W'(1);
                repeating_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rpt_q       <= '0;
            repeating_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            repeating_q <= repeating_d;
        end
    end
`else
    // Repeat timing is ignored in this build; the term folds to a constant 0.
    localparam bit REPEAT_CFG_SET = (REPEAT_DELAY != 0) || (REPEAT_PERIOD != 0);
    assign fire = 1'b0 & REPEAT_CFG_SET;
`endif

    assign A       = a_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: expected strobe cycles are queued when KEY0 is driven
// and matched by a monitor on the falling clock edge.
module tb_key_debouncer;

    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 6;
    localparam int LAT = DEB + 2;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic key;
    logic key_a;
    logic key_press;
    logic key_release;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int exp_press[$];
    int exp_rel[$];
    logic prev_a = 1'b0;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK50M  (clk),
        .RST     (rst),
        .KEY0    (key),
        .A       (key_a),
        .PRESS   (key_press),
        .RELEASE (key_release)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (key_press === 1'b1) begin
            n_assert++;
            if (exp_press.size() == 0) begin
                n_fail++;
                $display("FAIL press_unexpected: PRESS at cycle %0d, no press expected", cyc);
            end else begin
                int e;
                e = exp_press.pop_front();
                if (cyc != e) begin
                    n_fail++;
                    $display("FAIL press_cycle: PRESS at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
        if (key_release === 1'b1) begin
            n_assert++;
            if (exp_rel.size() == 0) begin
                n_fail++;
                $display("FAIL release_unexpected: RELEASE at cycle %0d, no release expected", cyc);
            end else begin
                int e;
                e = exp_rel.pop_front();
                if (cyc != e) begin
                    n_fail++;
                    $display("FAIL release_cycle: RELEASE at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
        if (key_press === 1'b1 && key_release === 1'b1) begin
            n_fail++;
            $display("FAIL strobe_overlap: PRESS and RELEASE both 1 at cycle %0d, required not both", cyc);
        end
        if (key_a === 1'b1 && prev_a === 1'b0) begin
            n_assert++;
            if (key_press !== 1'b1) begin
                n_fail++;
                $display("FAIL a_rise: A rose at cycle %0d with PRESS=%b, required PRESS=1", cyc, key_press);
            end
        end
        if (key_a === 1'b0 && prev_a === 1'b1 && rst !== 1'b1) begin
            n_assert++;
            if (key_release !== 1'b1) begin
                n_fail++;
                $display("FAIL a_fall: A fell at cycle %0d with RELEASE=%b, required RELEASE=1", cyc, key_release);
            end
        end
        prev_a = key_a;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected PRESS cycles for a key first sampled low at t0 and held low for hold cycles.
    task automatic push_hold(input int t0, input int hold);
        exp_press.push_back(t0 + LAT);
        if (RPT_ON) begin
            for (int e = t0 + LAT + RD + 1; e <= t0 + hold + 2; e += RP)
                exp_press.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        n_assert++;
        if (exp_press.size() != 0 || exp_rel.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d press / %0d release still expected, required 0/0",
                     name, exp_press.size(), exp_rel.size());
            exp_press.delete();
            exp_rel.delete();
        end
    endtask

    task automatic check_a(input string name, input logic required);
        n_assert++;
        if (key_a !== required) begin
            n_fail++;
            $display("FAIL %s: A=%b, required %b", name, key_a, required);
        end
    endtask

    // Key low for hold cycles, then released; release strobe LAT cycles after first high sample.
    task automatic press_and_release(input string name, input int hold);
        int t0;
        t0  = cyc + 1;
        key = 1'b0;
        push_hold(t0, hold);
        idle(hold);
        if (hold > LAT) check_a({name, "_held"}, 1'b1);
        if (hold >= DEB) exp_rel.push_back(cyc + 1 + LAT);
        key = 1'b1;
        idle(25);
        drain(name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        key = 1'b1;
        idle(3);
        n_assert += 3;
        if (key_a !== 1'b0)       begin n_fail++; $display("FAIL reset_a: A=%b, required 0", key_a); end
        if (key_press !== 1'b0)   begin n_fail++; $display("FAIL reset_press: PRESS=%b, required 0", key_press); end
        if (key_release !== 1'b0) begin n_fail++; $display("FAIL reset_release: RELEASE=%b, required 0", key_release); end
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_clean_press;
        press_and_release("clean_press", 40);
    endtask

    task automatic test_bounce;
        for (int seg = 0; seg < 10; seg++) begin
            key = (seg % 2 == 0) ? 1'b0 : 1'b1;
            idle(3);
        end
        check_a("bounce_no_early_a", 1'b0);
        press_and_release("bounce", 20);
    endtask

    task automatic test_glitch;
        key = 1'b0;
        idle(DEB - 1);
        key = 1'b1;
        idle(25);
        check_a("glitch_short_a", 1'b0);
        drain("glitch_short");
        press_and_release("glitch_min", DEB);
    endtask

    task automatic test_reset_mid;
        int t1;
        t1  = cyc + 1;
        key = 1'b0;
        push_hold(t1, 15);
        idle(15);
        check_a("reset_mid_pressed", 1'b1);
        key = 1'b1;
        idle(4);
        check_a("reset_mid_wait_up", 1'b1);
        key = 1'b0;
        rst = 1'b1;
        idle(1);
        check_a("reset_mid_a", 1'b0);
        n_assert++;
        if (key_release !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: RELEASE=%b, required 0", key_release);
        end
        idle(1);
        rst = 1'b0;
        press_and_release("reset_mid_repress", 15);
    endtask

    task automatic test_autorepeat;
        press_and_release("autorepeat", 56);
    endtask

    initial begin
        rst = 1'b1;
        key = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_autorepeat();
        drain("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
